// File: rtl/arr_wr_sched.sv
// Write-port scheduler sharing one registered array write port between a sweep engine and a host.
// Define ARR_SCHED_WRAP_EN for continuous wrap-around sweeping with a stop request on i_start.
module arr_wr_sched #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_en,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_fill,
  input  logic             i_hreq,
  input  logic [IDX_W-1:0] i_hidx,
  input  logic [WIDTH-1:0] i_hdata,
  output logic             o_hgnt,
  output logic             o_herr,
  output logic             o_we,
  output logic [IDX_W-1:0] o_widx,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [IDX_W:0]   DepthW  = DEPTH[IDX_W:0];
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] fill_q, fill_d;
  logic             rr_host_q, rr_host_d;  // 1: host won the last valid write
  logic             we_q, we_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             done_q, done_d;
`ifdef ARR_SCHED_WRAP_EN
  logic             stop_q, stop_d;
`endif

  logic sweep_req, sweep_gnt, host_gnt, hidx_ok, last_gnt;

  assign sweep_req = (state_q == StSweep) && i_en;
  assign sweep_gnt = (sweep_req && i_hreq) ? rr_host_q : sweep_req;
  assign host_gnt  = i_hreq && !sweep_gnt;
  assign hidx_ok   = {1'b0, i_hidx} < DepthW;
  assign last_gnt  = sweep_gnt && (ptr_q == LastIdx);

  assign o_hgnt  = host_gnt;
  assign o_herr  = host_gnt && !hidx_ok;
  assign o_we    = we_q;
  assign o_widx  = widx_q;
  assign o_wdata = wdata_q;
  assign o_busy  = (state_q == StSweep);
  assign o_done  = done_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    fill_d    = fill_q;
    rr_host_d = rr_host_q;
    we_d      = 1'b0;
    widx_d    = widx_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
`ifdef ARR_SCHED_WRAP_EN
    stop_d    = stop_q;
`endif

    if (sweep_gnt) begin
      we_d      = 1'b1;
      widx_d    = ptr_q;
      wdata_d   = fill_q;
      rr_host_d = 1'b0;
      if (last_gnt) begin
        ptr_d  = '0;
        done_d = 1'b1;
`ifdef ARR_SCHED_WRAP_EN
        fill_d = i_fill;
        if (stop_q || i_start) begin
          state_d = StIdle;
          stop_d  = 1'b0;
        end
`else
        state_d = StDone;
`endif
      end else begin
        ptr_d = ptr_q + IDX_W'(1);
      end
    end else if (host_gnt && hidx_ok) begin
      we_d      = 1'b1;
      widx_d    = i_hidx;
      wdata_d   = i_hdata;
      rr_host_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StSweep;
          ptr_d   = '0;
          fill_d  = i_fill;
`ifdef ARR_SCHED_WRAP_EN
          stop_d  = 1'b0;
`endif
        end
      end
      StSweep: begin
`ifdef ARR_SCHED_WRAP_EN
        // A start that lands on the boundary grant is already honoured above.
        if (i_start && !last_gnt) stop_d = 1'b1;
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      fill_q    <= '0;
      rr_host_q <= 1'b1;
      we_q      <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
`ifdef ARR_SCHED_WRAP_EN
      stop_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      fill_q    <= fill_d;
      rr_host_q <= rr_host_d;
      we_q      <= we_d;
      widx_q    <= widx_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
`ifdef ARR_SCHED_WRAP_EN
      stop_q    <= stop_d;
`endif
    end
  end

endmodule

// File: tb/tb_arr_wr_sched.sv
// Self-checking bench for arr_wr_sched: DEPTH=8 and DEPTH=6 instances share stimulus and are
// checked against a behavioural model, a vector table and hand-written corner sequences.
module tb_arr_wr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst, en, start, fill, hreq, hdata;
  logic [2:0] hidx;

  logic       hgnt_o[2], herr_o[2], we_o[2], wdata_o[2], busy_o[2], done_o[2];
  logic [2:0] widx_o[2];

  arr_wr_sched #(.DEPTH(8), .WIDTH(1)) u_dut8 (
    .i_clk(clk), .i_arst(arst), .i_en(en), .i_start(start), .i_fill(fill),
    .i_hreq(hreq), .i_hidx(hidx), .i_hdata(hdata),
    .o_hgnt(hgnt_o[0]), .o_herr(herr_o[0]), .o_we(we_o[0]), .o_widx(widx_o[0]),
    .o_wdata(wdata_o[0]), .o_busy(busy_o[0]), .o_done(done_o[0])
  );

  arr_wr_sched #(.DEPTH(6), .WIDTH(1)) u_dut6 (
    .i_clk(clk), .i_arst(arst), .i_en(en), .i_start(start), .i_fill(fill),
    .i_hreq(hreq), .i_hidx(hidx), .i_hdata(hdata),
    .o_hgnt(hgnt_o[1]), .o_herr(herr_o[1]), .o_we(we_o[1]), .o_widx(widx_o[1]),
    .o_wdata(wdata_o[1]), .o_busy(busy_o[1]), .o_done(done_o[1])
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 sweeping, 2 done-pulse; last 1 means host won last.
  int dep[2];
  int m_mode[2], m_pos[2], m_fill[2], m_last[2], m_stop[2];
  int m_we[2], m_widx[2], m_wdata[2], m_dn[2];
  int e_sw[2], e_hg[2], e_he[2];

  function automatic void model_comb(input int d);
    int sreq;
    sreq = (m_mode[d] == 1) && en;
    if (sreq && hreq) e_sw[d] = (m_last[d] == 1);
    else              e_sw[d] = sreq;
    e_hg[d] = hreq && !e_sw[d];
    e_he[d] = e_hg[d] && (int'(hidx) >= dep[d]);
  endfunction

  function automatic void model_edge(input int d);
    int old_mode;
    if (arst) begin
      m_mode[d] = 0; m_pos[d] = 0; m_fill[d] = 0; m_last[d] = 1; m_stop[d] = 0;
      m_we[d] = 0; m_widx[d] = 0; m_wdata[d] = 0; m_dn[d] = 0;
      return;
    end
    old_mode = m_mode[d];
    m_we[d] = 0;
    m_dn[d] = 0;
    if (e_sw[d]) begin
      m_we[d] = 1; m_widx[d] = m_pos[d]; m_wdata[d] = m_fill[d]; m_last[d] = 0;
      if (m_pos[d] == dep[d] - 1) begin
        m_dn[d] = 1;
        m_pos[d] = 0;
`ifdef ARR_SCHED_WRAP_EN
        m_fill[d] = fill;
        if (m_stop[d] || start) begin m_mode[d] = 0; m_stop[d] = 0; end
`else
        m_mode[d] = 2;
`endif
      end else begin
        m_pos[d]++;
`ifdef ARR_SCHED_WRAP_EN
        if (start) m_stop[d] = 1;
`endif
      end
    end else if (e_hg[d] && !e_he[d]) begin
      m_we[d] = 1; m_widx[d] = hidx; m_wdata[d] = hdata; m_last[d] = 1;
`ifdef ARR_SCHED_WRAP_EN
      if (old_mode == 1 && start) m_stop[d] = 1;
`endif
    end else begin
`ifdef ARR_SCHED_WRAP_EN
      if (old_mode == 1 && start) m_stop[d] = 1;
`endif
    end
    if (old_mode == 0 && start) begin
      m_mode[d] = 1; m_pos[d] = 0; m_fill[d] = fill; m_stop[d] = 0;
    end
    if (old_mode == 2) m_mode[d] = 0;
  endfunction

  function automatic int exp_done(input int d);
`ifdef ARR_SCHED_WRAP_EN
    return m_dn[d];
`else
    return int'(m_mode[d] == 2);
`endif
  endfunction

  // Outputs as sampled in the most recent tick.
  logic       s_hgnt[2], s_herr[2], s_we[2], s_wdata[2], s_busy[2], s_done[2];
  logic [2:0] s_widx[2];

  task automatic tick(input logic a, input logic e, input logic s, input logic f,
                      input logic hr, input logic [2:0] hi, input logic hd);
    @(negedge clk);
    arst = a; en = e; start = s; fill = f; hreq = hr; hidx = hi; hdata = hd;
    #1;
    for (int d = 0; d < 2; d++) begin
      model_comb(d);
      s_hgnt[d] = hgnt_o[d]; s_herr[d] = herr_o[d]; s_we[d] = we_o[d];
      s_widx[d] = widx_o[d]; s_wdata[d] = wdata_o[d]; s_busy[d] = busy_o[d];
      s_done[d] = done_o[d];
      if (chk_en) begin
        chk($sformatf("model%0d.we", d), we_o[d], m_we[d]);
        chk($sformatf("model%0d.widx", d), widx_o[d], m_widx[d]);
        chk($sformatf("model%0d.wdata", d), wdata_o[d], m_wdata[d]);
        chk($sformatf("model%0d.busy", d), busy_o[d], int'(m_mode[d] == 1));
        chk($sformatf("model%0d.done", d), done_o[d], exp_done(d));
        chk($sformatf("model%0d.hgnt", d), hgnt_o[d], e_hg[d]);
        chk($sformatf("model%0d.herr", d), herr_o[d], e_he[d]);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
  endtask

  typedef struct {
    logic       arst, en, start, fill, hreq;
    logic [2:0] hidx;
    logic       hdata;
    logic       we;
    logic [2:0] widx;
    logic       wdata, busy, done, hgnt, herr;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic a, e, s, f, hr, input logic [2:0] hi, input logic hd,
                              input logic we, input logic [2:0] wi,
                              input logic wd, bz, dn, hg, he);
    vec_t v;
    v.arst = a; v.en = e; v.start = s; v.fill = f; v.hreq = hr; v.hidx = hi; v.hdata = hd;
    v.we = we; v.widx = wi; v.wdata = wd; v.busy = bz; v.done = dn; v.hgnt = hg; v.herr = he;
    return v;
  endfunction

  initial begin
    int writes, host_writes, dn_cnt, hold;
    bit granted, seen;
    dep[0] = 8;
    dep[1] = 6;

    // Table: idle host writes, then a full single sweep on the DEPTH=8 instance.
    tbl[0] = mk(0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(0, 1, 0, 1, 1, 5, 0,  0, 0, 0, 0, 0, 1, 0);
    tbl[2] = mk(0, 1, 0, 1, 1, 2, 1,  1, 5, 0, 0, 0, 1, 0);
    tbl[3] = mk(0, 1, 1, 1, 0, 0, 0,  1, 2, 1, 0, 0, 0, 0);
    tbl[4] = mk(0, 1, 0, 1, 0, 0, 0,  0, 2, 1, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++)
      tbl[5+k] = mk(0, 1, 0, 1, 0, 0, 0,  1, 3'(k), 1, 1, 0, 0, 0);
`ifdef ARR_SCHED_WRAP_EN
    tbl[12] = mk(0, 1, 0, 1, 0, 0, 0,  1, 7, 1, 1, 1, 0, 0);
    tbl[13] = mk(0, 1, 0, 1, 0, 0, 0,  1, 0, 1, 1, 0, 0, 0);
`else
    tbl[12] = mk(0, 1, 0, 1, 0, 0, 0,  1, 7, 1, 0, 1, 0, 0);
    tbl[13] = mk(0, 1, 0, 1, 0, 0, 0,  0, 7, 1, 0, 0, 0, 0);
`endif

    tick(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].arst, tbl[i].en, tbl[i].start, tbl[i].fill, tbl[i].hreq, tbl[i].hidx,
           tbl[i].hdata);
      chk($sformatf("tbl[%0d].we", i), s_we[0], tbl[i].we);
      chk($sformatf("tbl[%0d].widx", i), s_widx[0], tbl[i].widx);
      chk($sformatf("tbl[%0d].wdata", i), s_wdata[0], tbl[i].wdata);
      chk($sformatf("tbl[%0d].busy", i), s_busy[0], tbl[i].busy);
      chk($sformatf("tbl[%0d].done", i), s_done[0], tbl[i].done);
      chk($sformatf("tbl[%0d].hgnt", i), s_hgnt[0], tbl[i].hgnt);
      chk($sformatf("tbl[%0d].herr", i), s_herr[0], tbl[i].herr);
    end

    // Sweep contending with a held host request: alternation, 9 writes total.
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 1, 0, 0, 0);
    writes = 0; host_writes = 0; granted = 0; seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      hold = !granted;
      tick(0, 1, 0, 1, 1'(hold), 5, 0);
      if (i == 0) chk("t2 tie goes to sweep", s_hgnt[0], 0);
      if (s_hgnt[0]) granted = 1;
      if (s_we[0]) writes++;
      if (s_we[0] && s_widx[0] == 5 && s_wdata[0] == 0) host_writes++;
      if (s_done[0]) seen = 1;
    end
    chk("t2 done seen", seen, 1);
    chk("t2 write cycles", writes, 9);
    chk("t2 host writes", host_writes, 1);

    // Enable dropped for 3 cycles after index 2 is granted.
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(0, 1'(!(i >= 3 && i <= 5)), 0, 1, 0, 0, 0);
      if (i == 3) chk("t4 write idx2", s_widx[0], 2);
      if (i >= 4 && i <= 6) begin
        chk($sformatf("t4 stall we c%0d", i), s_we[0], 0);
        chk($sformatf("t4 stall busy c%0d", i), s_busy[0], 1);
      end
      if (i == 7) begin
        chk("t4 resume we", s_we[0], 1);
        chk("t4 resume idx", s_widx[0], 3);
      end
    end

    // Reset mid-sweep at ptr=4, then restart from index 0.
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 1, 0, 0, 0);
    tick(1, 1, 0, 1, 0, 0, 0);
    tick(0, 1, 0, 1, 0, 0, 0);
    chk("t5 we after reset", s_we[0], 0);
    chk("t5 busy after reset", s_busy[0], 0);
    dn_cnt = int'(s_done[0]);
    for (int i = 0; i < 12; i++) begin
      tick(0, 1, 0, 1, 0, 0, 0);
      dn_cnt += int'(s_done[0]);
    end
    chk("t5 no done", dn_cnt, 0);
    tick(0, 1, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    chk("t5 restart we", s_we[0], 1);
    chk("t5 restart idx", s_widx[0], 0);

    // Out-of-range host index on the DEPTH=6 instance; arbitration history unchanged.
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 1, 1, 7, 1);
    chk("t3 hgnt6", s_hgnt[1], 1);
    chk("t3 herr6", s_herr[1], 1);
    chk("t3 herr8", s_herr[0], 0);
    tick(0, 1, 1, 1, 0, 0, 0);
    chk("t3 no write6", s_we[1], 0);
    chk("t3 write8", s_we[0], 1);
    tick(0, 1, 0, 1, 1, 1, 0);
    chk("t3 tie to sweep6", s_hgnt[1], 0);
    tick(1, 0, 0, 0, 0, 0, 0);

`ifdef ARR_SCHED_WRAP_EN
    // Continuous sweep, stop requested at index 3 of the second pass.
    tick(0, 1, 1, 1, 0, 0, 0);
    dn_cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(0, 1, 1'(i == 11), 1, 0, 0, 0);
      if (s_done[0]) begin
        dn_cnt++;
        chk($sformatf("t6 done idx pass%0d", dn_cnt), s_widx[0], 7);
        if (dn_cnt == 2) begin
          chk("t6 idle after stop", s_busy[0], 0);
          seen = 1;
        end
      end
    end
    chk("t6 done count", dn_cnt, 2);
    tick(0, 1, 0, 1, 0, 0, 0);
    chk("t6 no write after stop", s_we[0], 0);
    tick(1, 0, 0, 0, 0, 0, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
           3'($urandom_range(0, 7)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
